// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the two data-memory requesters, the arbiter and the
// single data-memory port. The arbiter uses the slave view; requesters/memory use master.
interface dmem_arbiter_if;
    // Requester 0: core load/store path
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [2:0]  m0_mode;
    logic        m0_gnt;
    logic        m0_done;
    logic [31:0] m0_rdata;

    // Requester 1: DMA / debug loader
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [2:0]  m1_mode;
    logic        m1_gnt;
    logic        m1_done;
    logic [31:0] m1_rdata;

    // Shared memory port and core freeze
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_mode;
    logic [31:0] mem_rdata;
    logic        core_stall;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_mode,
        output m0_gnt, m0_done, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_mode,
        output m1_gnt, m1_done, m1_rdata,
        output mem_rd_en, mem_wr_en, mem_addr, mem_wdata, mem_mode,
        input  mem_rdata,
        output core_stall
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_mode,
        input  m0_gnt, m0_done, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_mode,
        input  m1_gnt, m1_done, m1_rdata,
        input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata, mem_mode,
        output mem_rdata,
        input  core_stall
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single data-memory port: one access at a
// time, fixed memory latency, registered command, per-requester load data.
module dmem_arbiter #(
    parameter int unsigned MEM_LAT   = 1,     // strobe-to-rdata cycles, 1..8
    parameter bit          CORE_PRIO = 1'b0   // 0: round-robin, 1: requester 0 always wins
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [2:0] WAIT_LOAD = 3'(MEM_LAT - 1);

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic        last_q;
    logic        owner_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  mode_q;
    logic [31:0] m0_rdata_q;
    logic [31:0] m1_rdata_q;

    logic        any_req;
    logic        win_d;
    logic        we_d;
    logic [31:0] addr_d;
    logic [31:0] wdata_d;
    logic [2:0]  mode_d;

    logic        in_access;
    logic        in_done;
    logic        m0_done;

    // Winner selection and the command that would be latched at the IDLE edge.
    // NOTE: combinational blocks use blocking '=' and assign every output first,
    // so no latch is inferred when a branch is skipped.
    always_comb begin
        any_req = bus.m0_req | bus.m1_req;
        win_d   = bus.m1_req & ~bus.m0_req;
        if (bus.m0_req && bus.m1_req) begin
            win_d = CORE_PRIO ? 1'b0 : ~last_q;
        end

        we_d    = bus.m0_we;
        addr_d  = bus.m0_addr;
        wdata_d = bus.m0_wdata;
        mode_d  = bus.m0_mode;
        if (win_d) begin
            we_d    = bus.m1_we;
            addr_d  = bus.m1_addr;
            wdata_d = bus.m1_wdata;
            mode_d  = bus.m1_mode;
        end
    end

    // Single sequencing FSM; every piece of state lives here.
    // NOTE: sequential state uses non-blocking '<=' so all registers update
    // together from pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: the read-data holding registers are ordinary flops, not a memory
        // array, so they are cleared by reset along with the rest of the state.
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            mode_q     <= 3'd0;
            m0_rdata_q <= 32'd0;
            m1_rdata_q <= 32'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q <= ACCESS;
                        owner_q <= win_d;
                        last_q  <= win_d;
                        we_q    <= we_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        mode_q  <= mode_d;
                        cnt_q   <= WAIT_LOAD;
                    end
                end

                ACCESS: state_q <= WAIT;

                WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= DONE;
                        // Load data is valid in the last WAIT cycle only.
                        if (!we_q) begin
                            if (owner_q) m1_rdata_q <= bus.mem_rdata;
                            else         m0_rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end

                DONE: state_q <= IDLE;

                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_access = (state_q == ACCESS);
    assign in_done   = (state_q == DONE);
    assign m0_done   = in_done & ~owner_q;

    assign bus.m0_gnt   = in_access & ~owner_q;
    assign bus.m1_gnt   = in_access &  owner_q;
    assign bus.m0_done  = m0_done;
    assign bus.m1_done  = in_done & owner_q;
    assign bus.m0_rdata = m0_rdata_q;
    assign bus.m1_rdata = m1_rdata_q;

    assign bus.mem_rd_en = in_access & ~we_q;
    assign bus.mem_wr_en = in_access &  we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_mode  = mode_q;

    // The PC is frozen from the request cycle until the core's done pulse.
    assign bus.core_stall = bus.m0_req & ~m0_done;

    a_one_event: assert property (@(posedge clk) disable iff (!rst)
        $onehot0({bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done}));

    a_strobe_in_access: assert property (@(posedge clk) disable iff (!rst)
        (bus.mem_rd_en | bus.mem_wr_en) |-> in_access);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round-robin instance (MEM_LAT=2) and a
// fixed-priority instance (MEM_LAT=1) sharing clock and reset.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if bus_a ();
    dmem_arbiter_if bus_b ();

    dmem_arbiter #(.MEM_LAT(2), .CORE_PRIO(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    dmem_arbiter #(.MEM_LAT(1), .CORE_PRIO(1'b1)) dut_fp (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // {m0_gnt, m1_gnt, m0_done, m1_done, mem_rd_en, mem_wr_en}
    function automatic logic [5:0] st_a();
        return {bus_a.m0_gnt, bus_a.m1_gnt, bus_a.m0_done, bus_a.m1_done,
                bus_a.mem_rd_en, bus_a.mem_wr_en};
    endfunction

    function automatic logic [5:0] st_b();
        return {bus_b.m0_gnt, bus_b.m1_gnt, bus_b.m0_done, bus_b.m1_done,
                bus_b.mem_rd_en, bus_b.mem_wr_en};
    endfunction

    // Inputs are driven 1 time unit after the rising edge, outputs checked 2 later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic init_inputs();
        bus_a.m0_req = 1'b0; bus_a.m0_we = 1'b0; bus_a.m0_addr = '0;
        bus_a.m0_wdata = '0; bus_a.m0_mode = '0;
        bus_a.m1_req = 1'b0; bus_a.m1_we = 1'b0; bus_a.m1_addr = '0;
        bus_a.m1_wdata = '0; bus_a.m1_mode = '0;
        bus_a.mem_rdata = '0;
        bus_b.m0_req = 1'b0; bus_b.m0_we = 1'b0; bus_b.m0_addr = '0;
        bus_b.m0_wdata = '0; bus_b.m0_mode = '0;
        bus_b.m1_req = 1'b0; bus_b.m1_we = 1'b0; bus_b.m1_addr = '0;
        bus_b.m1_wdata = '0; bus_b.m1_mode = '0;
        bus_b.mem_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus_a.m0_req = 1'b1; bus_a.m0_addr = 32'h100;
        bus_a.m1_req = 1'b1; bus_a.m1_addr = 32'h200;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            settle();
            n_total++;
            if (st_a() !== 6'b0) $display("FAIL reset_status[%0d]: got %b want %b", i, st_a(), 6'b0);
            else n_pass++;
            n_total++;
            if ({bus_a.mem_addr, bus_a.mem_wdata, bus_a.m0_rdata, bus_a.m1_rdata} !== 128'd0)
                $display("FAIL reset_data[%0d]: got addr=%h rd0=%h rd1=%h want 0", i,
                         bus_a.mem_addr, bus_a.m0_rdata, bus_a.m1_rdata);
            else n_pass++;
        end
        rst = 1'b1;
        next_cycle();
        settle();
        n_total++;
        if (st_a() !== 6'b100010) $display("FAIL reset_first_grant: got %b want %b", st_a(), 6'b100010);
        else n_pass++;
        n_total++;
        if (bus_a.mem_addr !== 32'h100) $display("FAIL reset_first_addr: got %h want %h", bus_a.mem_addr, 32'h100);
        else n_pass++;
        bus_a.m0_req = 1'b0;
        bus_a.m1_req = 1'b0;
        repeat (3) next_cycle();
        settle();
        n_total++;
        if (st_a() !== 6'b001000) $display("FAIL reset_first_done: got %b want %b", st_a(), 6'b001000);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_read();
        bus_a.m0_req = 1'b1; bus_a.m0_we = 1'b0; bus_a.m0_addr = 32'h10;
        bus_a.m0_mode = 3'b010; bus_a.mem_rdata = 32'h0BAD_0BAD;
        settle();
        n_total++;
        if (bus_a.core_stall !== 1'b1) $display("FAIL read_stall_t: got %b want 1", bus_a.core_stall);
        else n_pass++;
        next_cycle();  // t+1
        settle();
        n_total++;
        if (st_a() !== 6'b100010) $display("FAIL read_gnt: got %b want %b", st_a(), 6'b100010);
        else n_pass++;
        n_total++;
        if ({bus_a.mem_addr, bus_a.mem_mode, bus_a.core_stall} !== {32'h10, 3'b010, 1'b1})
            $display("FAIL read_cmd: got addr=%h mode=%b stall=%b want addr=10 mode=010 stall=1",
                     bus_a.mem_addr, bus_a.mem_mode, bus_a.core_stall);
        else n_pass++;
        next_cycle();  // t+2
        settle();
        n_total++;
        if ({st_a(), bus_a.core_stall} !== 7'b0000001) $display("FAIL read_wait1: got %b want %b", {st_a(), bus_a.core_stall}, 7'b0000001);
        else n_pass++;
        next_cycle();  // t+3: final WAIT, memory data valid
        bus_a.mem_rdata = 32'hDEAD_BEEF;
        settle();
        n_total++;
        if ({st_a(), bus_a.core_stall} !== 7'b0000001) $display("FAIL read_wait2: got %b want %b", {st_a(), bus_a.core_stall}, 7'b0000001);
        else n_pass++;
        next_cycle();  // t+4: DONE
        bus_a.mem_rdata = 32'h0BAD_0BAD;
        settle();
        n_total++;
        if ({st_a(), bus_a.core_stall} !== 7'b0010000) $display("FAIL read_done: got %b want %b", {st_a(), bus_a.core_stall}, 7'b0010000);
        else n_pass++;
        n_total++;
        if (bus_a.m0_rdata !== 32'hDEAD_BEEF) $display("FAIL read_rdata: got %h want %h", bus_a.m0_rdata, 32'hDEAD_BEEF);
        else n_pass++;
        n_total++;
        if (bus_a.m1_rdata !== 32'h0) $display("FAIL read_m1_rdata: got %h want 0", bus_a.m1_rdata);
        else n_pass++;
        next_cycle();  // t+5: IDLE, request withdrawn
        bus_a.m0_req = 1'b0;
        settle();
        n_total++;
        if (bus_a.m0_rdata !== 32'hDEAD_BEEF) $display("FAIL read_rdata_hold: got %h want %h", bus_a.m0_rdata, 32'hDEAD_BEEF);
        else n_pass++;
        next_cycle();  // t+6
        settle();
        n_total++;
        if (st_a() !== 6'b0) $display("FAIL read_no_regrant: got %b want %b", st_a(), 6'b0);
        else n_pass++;
    endtask

    task automatic test_write();
        bus_a.m1_req = 1'b1; bus_a.m1_we = 1'b1; bus_a.m1_addr = 32'h20;
        bus_a.m1_wdata = 32'h1234_5678; bus_a.m1_mode = 3'b010;
        bus_a.mem_rdata = 32'hFFFF_FFFF;
        next_cycle();  // t+1: ACCESS; inputs change after the grant edge
        bus_a.m1_req = 1'b0; bus_a.m1_addr = 32'h99; bus_a.m1_wdata = 32'h0; bus_a.m1_mode = 3'b000;
        settle();
        n_total++;
        if (st_a() !== 6'b010001) $display("FAIL write_gnt: got %b want %b", st_a(), 6'b010001);
        else n_pass++;
        n_total++;
        if ({bus_a.mem_addr, bus_a.mem_wdata, bus_a.mem_mode} !== {32'h20, 32'h1234_5678, 3'b010})
            $display("FAIL write_cmd: got %h/%h/%b want 20/12345678/010",
                     bus_a.mem_addr, bus_a.mem_wdata, bus_a.mem_mode);
        else n_pass++;
        next_cycle();  // t+2
        settle();
        n_total++;
        if (st_a() !== 6'b0) $display("FAIL write_strobe_once: got %b want %b", st_a(), 6'b0);
        else n_pass++;
        repeat (2) next_cycle();  // t+4: DONE
        settle();
        n_total++;
        if (st_a() !== 6'b000100) $display("FAIL write_done: got %b want %b", st_a(), 6'b000100);
        else n_pass++;
        n_total++;
        if ({bus_a.m1_rdata, bus_a.m0_rdata, bus_a.mem_addr} !== {32'h0, 32'hDEAD_BEEF, 32'h20})
            $display("FAIL write_rdata: got rd1=%h rd0=%h addr=%h want 0/deadbeef/20",
                     bus_a.m1_rdata, bus_a.m0_rdata, bus_a.mem_addr);
        else n_pass++;
        next_cycle();  // t+5: IDLE
        bus_a.m1_we = 1'b0;
        bus_a.mem_rdata = 32'h0;
    endtask

    task automatic test_contention();
        int          n_gnt = 0;
        int          viol  = 0;
        logic [3:0]  who   = '0;
        int          at [4];
        bus_a.m0_req = 1'b1; bus_a.m0_addr = 32'h30;
        bus_a.m1_req = 1'b1; bus_a.m1_addr = 32'h50;
        for (int i = 0; i < 4; i++) at[i] = -1;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (bus_a.m0_gnt || bus_a.m1_gnt) begin
                if (n_gnt < 4) begin
                    who[n_gnt] = bus_a.m1_gnt;
                    at[n_gnt]  = i;
                end
                n_gnt++;
            end
            if (!$onehot0({bus_a.m0_gnt, bus_a.m1_gnt, bus_a.m0_done, bus_a.m1_done})) viol++;
            next_cycle();
        end
        bus_a.m0_req = 1'b0;
        bus_a.m1_req = 1'b0;
        n_total++;
        if (n_gnt !== 4) $display("FAIL rr_grant_count: got %0d want 4", n_gnt);
        else n_pass++;
        n_total++;
        if (who !== 4'b1010) $display("FAIL rr_order: got %b want %b (bit k = owner of grant k)", who, 4'b1010);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (at[k] !== 1 + 5 * k) $display("FAIL rr_grant_cycle[%0d]: got %0d want %0d", k, at[k], 1 + 5 * k);
            else n_pass++;
        end
        n_total++;
        if (viol !== 0) $display("FAIL rr_one_event: got %0d violations want 0", viol);
        else n_pass++;
    endtask

    task automatic test_stability();
        bus_a.m0_req = 1'b1; bus_a.m0_we = 1'b0; bus_a.m0_addr = 32'h10;
        next_cycle();  // t+1: ACCESS
        settle();
        n_total++;
        if (bus_a.mem_addr !== 32'h10) $display("FAIL stab_addr_gnt: got %h want %h", bus_a.mem_addr, 32'h10);
        else n_pass++;
        next_cycle();  // t+2: requester changes its address mid-access
        bus_a.m0_addr = 32'h40;
        settle();
        n_total++;
        if (bus_a.mem_addr !== 32'h10) $display("FAIL stab_addr_wait: got %h want %h", bus_a.mem_addr, 32'h10);
        else n_pass++;
        next_cycle();  // t+3
        bus_a.mem_rdata = 32'h1111_2222;
        next_cycle();  // t+4: DONE, req still held
        bus_a.mem_rdata = 32'h0;
        settle();
        n_total++;
        if ({bus_a.m0_done, bus_a.m0_rdata, bus_a.mem_addr} !== {1'b1, 32'h1111_2222, 32'h10})
            $display("FAIL stab_done: got done=%b rd=%h addr=%h want 1/11112222/10",
                     bus_a.m0_done, bus_a.m0_rdata, bus_a.mem_addr);
        else n_pass++;
        next_cycle();  // t+5: IDLE holds the previous address
        settle();
        n_total++;
        if ({st_a(), bus_a.mem_addr} !== {6'b0, 32'h10}) $display("FAIL stab_idle_hold: got %b/%h want 000000/10", st_a(), bus_a.mem_addr);
        else n_pass++;
        next_cycle();  // t+6: held request is a new access
        settle();
        n_total++;
        if ({st_a(), bus_a.mem_addr} !== {6'b100010, 32'h40}) $display("FAIL stab_regrant: got %b/%h want 100010/40", st_a(), bus_a.mem_addr);
        else n_pass++;
        bus_a.m0_req = 1'b0;
        repeat (3) next_cycle();
        settle();
        n_total++;
        if (st_a() !== 6'b001000) $display("FAIL stab_regrant_done: got %b want %b", st_a(), 6'b001000);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_mid_reset();
        bus_a.m0_req = 1'b1; bus_a.m0_addr = 32'h60;
        next_cycle();  // t+1: ACCESS (m0 now last granted)
        bus_a.m0_req = 1'b0;
        settle();
        n_total++;
        if (st_a() !== 6'b100010) $display("FAIL mid_gnt: got %b want %b", st_a(), 6'b100010);
        else n_pass++;
        next_cycle();  // t+2: WAIT, reset asserted for this edge
        rst = 1'b0;
        next_cycle();  // t+3: IDLE after reset
        rst = 1'b1;
        bus_a.m0_req = 1'b1; bus_a.m0_addr = 32'h70;
        bus_a.m1_req = 1'b1; bus_a.m1_addr = 32'h80;
        settle();
        n_total++;
        if ({st_a(), bus_a.mem_addr, bus_a.m0_rdata} !== {6'b0, 32'h0, 32'h0})
            $display("FAIL mid_after_reset: got %b/%h/%h want 000000/0/0", st_a(), bus_a.mem_addr, bus_a.m0_rdata);
        else n_pass++;
        next_cycle();  // t+4: tie goes to m0 again
        bus_a.m0_req = 1'b0;
        bus_a.m1_req = 1'b0;
        settle();
        n_total++;
        if ({st_a(), bus_a.mem_addr} !== {6'b100010, 32'h70}) $display("FAIL mid_tie_m0: got %b/%h want 100010/70", st_a(), bus_a.mem_addr);
        else n_pass++;
        repeat (3) next_cycle();
        settle();
        n_total++;
        if (st_a() !== 6'b001000) $display("FAIL mid_done: got %b want %b", st_a(), 6'b001000);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_fixed_prio();
        int          n_gnt   = 0;
        int          viol    = 0;
        logic [3:0]  who     = '0;
        int          at [4];
        int          done_at = -1;
        logic [31:0] done_rd = '0;
        bus_b.m0_req = 1'b1; bus_b.m0_addr = 32'h300;
        bus_b.m1_req = 1'b1; bus_b.m1_addr = 32'h400;
        for (int i = 0; i < 4; i++) at[i] = -1;
        for (int i = 0; i < 16; i++) begin
            bus_b.mem_rdata = 32'hA000_0000 + 32'(i);
            settle();
            if (bus_b.m0_gnt || bus_b.m1_gnt) begin
                if (n_gnt < 4) begin
                    who[n_gnt] = bus_b.m1_gnt;
                    at[n_gnt]  = i;
                end
                n_gnt++;
            end
            if (bus_b.m0_done && done_at < 0) begin
                done_at = i;
                done_rd = bus_b.m0_rdata;
            end
            if (!$onehot0({bus_b.m0_gnt, bus_b.m1_gnt, bus_b.m0_done, bus_b.m1_done})) viol++;
            next_cycle();
        end
        bus_b.m0_req = 1'b0;
        bus_b.m1_req = 1'b0;
        n_total++;
        if (n_gnt !== 4 || who !== 4'b0000) $display("FAIL fp_grants: got count=%0d owners=%b want 4/0000", n_gnt, who);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (at[k] !== 1 + 4 * k) $display("FAIL fp_grant_cycle[%0d]: got %0d want %0d", k, at[k], 1 + 4 * k);
            else n_pass++;
        end
        n_total++;
        if (done_at !== 3) $display("FAIL fp_done_cycle: got %0d want 3", done_at);
        else n_pass++;
        n_total++;
        if (done_rd !== 32'hA000_0002) $display("FAIL fp_rdata: got %h want %h", done_rd, 32'hA000_0002);
        else n_pass++;
        n_total++;
        if ({viol, bus_b.m1_rdata} !== {32'd0, 32'h0}) $display("FAIL fp_m1_quiet: got viol=%0d rd1=%h want 0/0", viol, bus_b.m1_rdata);
        else n_pass++;
        settle();
        n_total++;
        if (st_b() !== 6'b0) $display("FAIL fp_idle_end: got %b want %b", st_b(), 6'b0);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b0;
        init_inputs();
        test_reset();
        test_read();
        test_write();
        test_contention();
        test_stability();
        test_mid_reset();
        test_fixed_prio();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish before 200000");
        $fatal(1, "bench timeout");
    end
endmodule
